// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM states,
// parity mode encodings and the oversample rate.
package uart_pkg;

    localparam int unsigned OS_RATE  = 16;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with valid/ready read port. A push into a full FIFO is
// accepted only when a pop happens on the same edge.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    output logic                       full,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             pop;
    logic             wr_en;

    assign full      = (count_q == CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign wr_en     = push & (~full | pop);
    assign count     = count_q;
    // Storage is not reset, so the head is masked to keep out_data at 0 when empty.
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling UART receiver: input synchroniser, prescaler, framing FSM
// with 2-of-3 majority bit decisions, and a receive FIFO with sticky overrun.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY      = 0,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_i,
    input  logic [15:0]                   div_i,
    input  logic                          en_i,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [7:0]                    out_data,
    output logic                          out_frame_err,
    output logic                          out_parity_err,
    output logic                          overrun_o,
    input  logic                          overrun_clr_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_rx_os: DATA_BITS must be 5..8");
    end
    if (PARITY > 2) begin : g_bad_parity
        $error("uart_rx_os: PARITY must be 0, 1 or 2");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_os: FIFO_DEPTH must be a power of two in 2..256");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("uart_rx_os: SYNC_STAGES must be at least 2");
    end

    logic [1:0]             rst_pipe;
    logic                   rst_int_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_prev;
    logic                   fall;
    logic [15:0]            presc;
    logic [15:0]            div_q;
    logic                   tick;
    logic [3:0]             tick_cnt;
    logic [2:0]             bit_idx;
    logic                   s7;
    logic                   s8;
    logic                   maj;
    logic                   par_x;
    logic [7:0]             data_q;
    logic                   par_err_q;
    rx_state_e              state;
    logic                   push;
    logic                   fifo_full;
    logic [9:0]             head;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_pipe <= '0;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end
    assign rst_int_n = rst_pipe[1];

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign rx_s  = sync_q[SYNC_STAGES-1];
    assign fall  = rx_prev & ~rx_s;
    assign tick  = (presc == div_q);
    assign maj   = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
    assign par_x = (^data_q) ^ maj;
    assign push  = en_i && (state == ST_STOP) && tick && (tick_cnt == 4'd9);

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            rx_prev   <= 1'b1;
            presc     <= '0;
            div_q     <= '0;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            s7        <= 1'b0;
            s8        <= 1'b0;
            data_q    <= '0;
            par_err_q <= 1'b0;
            state     <= ST_IDLE;
        end else begin
            rx_prev <= rx_s;
            // A new divisor only takes effect at a wrap so ticks stay evenly spaced.
            if (tick) begin
                presc <= '0;
                div_q <= div_i;
            end else begin
                presc <= presc + 16'd1;
            end

            if (!en_i) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (fall) begin
                            presc     <= '0;
                            div_q     <= div_i;
                            tick_cnt  <= '0;
                            bit_idx   <= '0;
                            data_q    <= '0;
                            par_err_q <= 1'b0;
                            state     <= ST_START;
                        end
                    end
                    ST_BREAK: begin
                        if (rx_s) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        if (tick) begin
                            tick_cnt <= tick_cnt + 4'd1;
                            if (tick_cnt == 4'd7) s7 <= rx_s;
                            if (tick_cnt == 4'd8) s8 <= rx_s;
                            if (tick_cnt == 4'd9) begin
                                case (state)
                                    ST_START:  if (maj) state <= ST_IDLE;
                                    ST_DATA:   data_q[bit_idx] <= maj;
                                    ST_PARITY: par_err_q <= (PARITY == PAR_ODD) ? ~par_x : par_x;
                                    ST_STOP:   state <= maj ? ST_IDLE : ST_BREAK;
                                    default:   state <= state;
                                endcase
                            end
                            if (tick_cnt == 4'd15) begin
                                case (state)
                                    ST_START:  state <= ST_DATA;
                                    ST_DATA: begin
                                        if (bit_idx == LAST_BIT) begin
                                            state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                                        end else begin
                                            bit_idx <= bit_idx + 3'd1;
                                        end
                                    end
                                    ST_PARITY: state <= ST_STOP;
                                    default:   state <= state;
                                endcase
                            end
                        end
                    end
                endcase
            end
        end
    end

    // A new overrun wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            overrun_o <= 1'b0;
        end else if (push && fifo_full && !(out_valid && out_ready)) begin
            overrun_o <= 1'b1;
        end else if (overrun_clr_i) begin
            overrun_o <= 1'b0;
        end
    end

    uart_sync_fifo #(
        .WIDTH (10),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_int_n),
        .push      (push),
        .push_data ({data_q, ~maj, par_err_q}),
        .full      (fifo_full),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head),
        .count     (fifo_count)
    );

    assign out_data       = head[9:2];
    assign out_frame_err  = head[1];
    assign out_parity_err = head[0];

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 Parameter DATA_BITS, default 8, data bits per frame, legal 5..8.
REQ-002 Parameter PARITY, default 0, 0 none / 1 odd / 2 even.
REQ-003 Parameter FIFO_DEPTH, default 16, receive FIFO entries, power of two, 2..256.
REQ-004 Parameter SYNC_STAGES, default 2, rx input synchroniser flops, minimum 2.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 rx_i  input  1  serial line, asynchronous to clk, idle high.
REQ-008 div_i  input  16  clk cycles per oversample tick minus 1 (tick every div_i+1 clocks); 16 ticks per bit.
REQ-009 en_i  input  1  receiver enable; 0 forces FSM to IDLE, FIFO contents kept.
REQ-010 out_valid  output  1  FIFO head entry valid.
REQ-011 out_ready  input  1  consumer accepts head when out_valid and out_ready high at clock edge.
REQ-012 out_data  output  8  received data, LSB first on line, unused upper bits 0.
REQ-013 out_frame_err  output  1  head entry had stop bit sampled 0.
REQ-014 out_parity_err  output  1  head entry failed parity check (always 0 when PARITY=0).
REQ-015 overrun_o  output  1  sticky: frame dropped because FIFO full.
REQ-016 overrun_clr_i  input  1  clears overrun_o.
REQ-017 fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-018 rx_i SHALL pass SYNC_STAGES flops (reset value 1) before any use; all timing below is relative to the synchronised signal.
REQ-019 Prescaler SHALL count 0..div_i and emit a one-clock tick on reaching div_i, then wrap to 0; div_i=0 ticks every clock.
REQ-020 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-021 IDLE: on synchronised falling edge with en_i=1, SHALL zero prescaler and 4-bit tick counter and enter START.
REQ-022 Each bit SHALL be sampled at ticks 7, 8, 9 and decided by 2-of-3 majority; state advance occurs on tick 15.
REQ-023 START: majority 1 SHALL be a false start, return to IDLE, push nothing.
REQ-024 DATA: SHALL shift in exactly DATA_BITS bits LSB first, then PARITY (if PARITY!=0), else STOP.
REQ-025 PARITY: error when XOR(data, parity bit) is 0 for odd or 1 for even.
REQ-026 STOP: at tick 9 SHALL push {data, frame_err, parity_err}; frame_err when stop majority is 0; next state IDLE if stop 1, else BREAK.
REQ-027 BREAK: SHALL wait for synchronised rx high, then IDLE; no pushes while in BREAK.
REQ-028 out_valid SHALL rise the clock after the push edge (push-to-valid latency 1 clock when FIFO was empty).
REQ-029 FIFO full at push with no pop same cycle: frame dropped, overrun_o set next clock; full with pop same cycle: push accepted, no overrun.
REQ-030 overrun_clr_i and a new overrun in same cycle: overrun_o stays 1.
REQ-031 en_i falling mid-frame SHALL abort the frame with no push; out-of-range DATA_BITS or PARITY is a configuration error (elaboration assertion).
REQ-032 div_i changes are honoured at the next prescaler wrap; mid-frame changes are undefined for that frame only.

Reset
REQ-033 On rst_n low: FSM IDLE, counters 0, synchroniser 1s, FIFO empty, out_valid 0, out_data 0, both error outputs 0, overrun_o 0, fifo_count 0.
REQ-034 Reset release SHALL be synchronous to clk; no frame starts earlier than SYNC_STAGES clocks after release.

Structure
REQ-035 Package uart_pkg SHALL hold the FSM state enum, parity mode constants, and OS_RATE=16.
REQ-036 FIFO SHALL be sub-module uart_sync_fifo (parametrised width/depth, valid/ready read port, full/count outputs); FSM and prescaler in uart_rx_os.

Verification
REQ-037 div_i=3, 8N1, send 0x55 then 0xA3 -> two entries in order, no errors, out_valid 1 clock after each stop tick 9.
REQ-038 PARITY=2, send 0x07 with parity bit 0 -> out_data 0x07, out_parity_err 1; with bit 1 -> error 0.
REQ-039 rx low for 5 oversample ticks then high -> false start, fifo_count stays 0.
REQ-040 Send 0x00 with stop 0 and line held low 3 bit times -> one entry frame_err 1, no further entries until line high.
REQ-041 FIFO_DEPTH=4, out_ready=0, send 5 bytes -> count 4, overrun_o 1, 5th byte lost; overrun_clr_i pulse -> 0; pop coinciding with 5th push -> no overrun.
REQ-042 Assert rst_n low mid DATA, release, send 0x3C -> single clean entry 0x3C, no partial frame.
